// File: rtl/ad_sp_trig_gen.sv
// -----------------------------------------------------------------------------
// ad_sp_trig_gen
//
// Line-sensor timing transmitter. A frame request launches one start pulse
// (AD_sp_signal), an optional idle gap, then PIXELS trigger pulses
// (AD_trig_signal) of TRIG_WIDTH high / TRIG_PERIOD total clocks each. The
// trigger train runs inside the diode-output window (signal_to_diods_output).
// Every frame, whether it completes or is aborted, ends with a one-cycle
// reset_after_end_frame strobe.
//
// Ports
//   clk_200MHz_i           in   200 MHz system clock
//   reset_n                in   asynchronous active-low reset
//   frame_req_i            in   start-frame request, level-sampled
//   abort_i                in   synchronous frame abort
//   AD_sp_signal           out  frame start pulse
//   AD_trig_signal         out  pixel trigger pulse
//   signal_to_diods_output out  diode-output window
//   reset_after_end_frame  out  one-cycle end-of-frame strobe
//   busy_o                 out  frame in progress
//   pixel_idx_o            out  current pixel index, 0-based
//
// Build option
//   AD_SP_AUTO_REPEAT_EN   when defined, a request present during the end
//                          strobe starts the next frame immediately (no idle
//                          cycle). Undefined: END always returns to IDLE.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for frame_req_i, all outputs low
// S_SP      | start pulse high, SP_WIDTH cycles
// S_GAP     | idle gap before first trigger, SP_TO_TRIG cycles
// S_TRIG_HI | trigger high, TRIG_WIDTH cycles
// S_TRIG_LO | trigger low, TRIG_PERIOD - TRIG_WIDTH cycles
// S_END     | end-of-frame strobe, one cycle, busy still high
// -----------------------------------------------------------------------------
module ad_sp_trig_gen #(
  parameter int PIXELS      = 1024,
  parameter int SP_WIDTH    = 4,
  parameter int SP_TO_TRIG  = 8,
  parameter int TRIG_PERIOD = 20,
  parameter int TRIG_WIDTH  = 10,
  localparam int PIX_W      = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic             clk_200MHz_i,
  input  logic             reset_n,
  input  logic             frame_req_i,
  input  logic             abort_i,
  output logic             AD_sp_signal,
  output logic             AD_trig_signal,
  output logic             signal_to_diods_output,
  output logic             reset_after_end_frame,
  output logic             busy_o,
  output logic [PIX_W-1:0] pixel_idx_o
);

  localparam int CNT_MAX_A = (SP_WIDTH > SP_TO_TRIG) ? SP_WIDTH : SP_TO_TRIG;
  localparam int CNT_MAX   = (CNT_MAX_A > TRIG_PERIOD) ? CNT_MAX_A : TRIG_PERIOD;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Phase counter is loaded with (duration - 1) on entry and the state is
  // left on the cycle it reads zero, so the largest load is CNT_MAX - 1.
  localparam logic [CNT_W-1:0] SP_LOAD  = CNT_W'(SP_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((SP_TO_TRIG > 0) ? SP_TO_TRIG - 1 : 0);
  localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(TRIG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LO_LOAD  = CNT_W'(TRIG_PERIOD - TRIG_WIDTH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  if (PIXELS < 1 || SP_WIDTH < 1 || SP_TO_TRIG < 0 || TRIG_WIDTH < 1 ||
      TRIG_PERIOD <= TRIG_WIDTH) begin : g_bad_params
    $error("ad_sp_trig_gen: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SP,
    S_GAP,
    S_TRIG_HI,
    S_TRIG_LO,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;

    unique case (state_q)
      S_IDLE: begin
        // A request wins over a simultaneous abort here.
        if (frame_req_i) begin
          state_d = S_SP;
          cnt_d   = SP_LOAD;
          pix_d   = '0;
        end
      end

      S_SP, S_GAP, S_TRIG_HI, S_TRIG_LO: begin
        if (abort_i) begin
          state_d = S_END;
          cnt_d   = '0;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          unique case (state_q)
            S_SP: begin
              if (SP_TO_TRIG == 0) begin
                state_d = S_TRIG_HI;
                cnt_d   = HI_LOAD;
              end else begin
                state_d = S_GAP;
                cnt_d   = GAP_LOAD;
              end
            end
            S_GAP: begin
              state_d = S_TRIG_HI;
              cnt_d   = HI_LOAD;
            end
            S_TRIG_HI: begin
              state_d = S_TRIG_LO;
              cnt_d   = LO_LOAD;
            end
            default: begin
              // End of a pixel's low phase: next pixel or frame end.
              if (pix_q == PIX_LAST) begin
                state_d = S_END;
                cnt_d   = '0;
              end else begin
                state_d = S_TRIG_HI;
                cnt_d   = HI_LOAD;
                pix_d   = pix_q + PIX_W'(1);
              end
            end
          endcase
        end
      end

      S_END: begin
`ifdef AD_SP_AUTO_REPEAT_EN
        if (frame_req_i) begin
          state_d = S_SP;
          cnt_d   = SP_LOAD;
          pix_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pix_d   = '0;
        end
`else
        state_d = S_IDLE;
        cnt_d   = '0;
        pix_d   = '0;
`endif
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pix_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state they describe.
  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= S_IDLE;
      cnt_q                  <= '0;
      pix_q                  <= '0;
      AD_sp_signal           <= 1'b0;
      AD_trig_signal         <= 1'b0;
      signal_to_diods_output <= 1'b0;
      reset_after_end_frame  <= 1'b0;
      busy_o                 <= 1'b0;
      pixel_idx_o            <= '0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      pix_q                  <= pix_d;
      AD_sp_signal           <= (state_d == S_SP);
      AD_trig_signal         <= (state_d == S_TRIG_HI);
      signal_to_diods_output <= (state_d == S_SP) || (state_d == S_GAP) ||
                                (state_d == S_TRIG_HI) || (state_d == S_TRIG_LO);
      reset_after_end_frame  <= (state_d == S_END);
      busy_o                 <= (state_d != S_IDLE);
      pixel_idx_o            <= pix_d;
    end
  end

endmodule

// File: tb/tb_ad_sp_trig_gen.sv
module tb_ad_sp_trig_gen;

  localparam int P     = 4;
  localparam int SPW   = 2;
  localparam int GAP   = 3;
  localparam int PER   = 4;
  localparam int TW    = 2;
  localparam int T1    = 1 + SPW + GAP;   // cycle offset of first trigger
  localparam int END_K = T1 + P * PER;    // cycle offset of end strobe
`ifdef AD_SP_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req, abort, req_e, abort_e;
  logic sp, trig, win, stb, busy;
  logic [1:0] pix;
  logic sp_e, trig_e, win_e, stb_e, busy_e;
  logic [0:0] pix_e;
  logic [6:0] obs;
  logic [5:0] obs_e;

  assign obs   = {sp, trig, win, stb, busy, pix};
  assign obs_e = {sp_e, trig_e, win_e, stb_e, busy_e, pix_e};

  ad_sp_trig_gen #(.PIXELS(P), .SP_WIDTH(SPW), .SP_TO_TRIG(GAP),
                   .TRIG_PERIOD(PER), .TRIG_WIDTH(TW)) u_dut (
    .clk_200MHz_i(clk), .reset_n(rst_n), .frame_req_i(req), .abort_i(abort),
    .AD_sp_signal(sp), .AD_trig_signal(trig), .signal_to_diods_output(win),
    .reset_after_end_frame(stb), .busy_o(busy), .pixel_idx_o(pix));

  ad_sp_trig_gen #(.PIXELS(1), .SP_WIDTH(2), .SP_TO_TRIG(0),
                   .TRIG_PERIOD(4), .TRIG_WIDTH(2)) u_edge (
    .clk_200MHz_i(clk), .reset_n(rst_n), .frame_req_i(req_e), .abort_i(abort_e),
    .AD_sp_signal(sp_e), .AD_trig_signal(trig_e), .signal_to_diods_output(win_e),
    .reset_after_end_frame(stb_e), .busy_o(busy_e), .pixel_idx_o(pix_e));

  int n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check(name, busy, 0);
    step();
  endtask

  // Behavioural reference: a frame is a timeline of offsets k = 1..endk after
  // the accepting edge; outputs are pure arithmetic on k.
  bit m_active;
  int m_k, m_endk, m_pix_last;

  task automatic model_step(input bit r, input bit a);
    if (!m_active) begin
      if (r) begin m_active = 1; m_k = 1; m_endk = END_K; end
    end else if (m_k == m_endk) begin
      if (AUTO && r) begin m_k = 1; m_endk = END_K; end
      else m_active = 0;
    end else if (a) begin
      m_k = m_k + 1;
      m_endk = m_k;
    end else begin
      m_k = m_k + 1;
    end
  endtask

  task automatic model_out(output logic [6:0] e);
    int p;
    if (!m_active) begin
      e = 7'b0;
    end else if (m_k == m_endk) begin
      e = {3'b000, 1'b1, 1'b1, 2'(m_pix_last)};
    end else begin
      p = (m_k >= T1) ? (m_k - T1) / PER : 0;
      m_pix_last = p;
      e = {1'(m_k <= SPW), 1'(m_k >= T1 && ((m_k - T1) % PER) < TW),
           1'b1, 1'b0, 1'b1, 2'(p)};
    end
  endtask

  typedef struct {
    logic       req;
    logic       abort;
    logic [6:0] exp;   // {sp, trig, win, stb, busy, pix[1:0]}
  } vec_t;
  vec_t tbl[24];

  int   rises[$];
  int   first_stb, stray, busy_low, trig_rises, n_stb, first_trig;
  logic prev_sp, prev_trig, hold, r, a;
  logic [6:0] e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; req = 1'b0; abort = 1'b0; req_e = 1'b0; abort_e = 1'b0;

    // Entry i: inputs during cycle i, expected outputs in cycle i+1.
    tbl[0]  = '{1'b1, 1'b0, 7'b1010100};
    tbl[1]  = '{1'b0, 1'b0, 7'b1010100};
    tbl[2]  = '{1'b0, 1'b0, 7'b0010100};
    tbl[3]  = '{1'b0, 1'b0, 7'b0010100};
    tbl[4]  = '{1'b0, 1'b0, 7'b0010100};
    tbl[5]  = '{1'b0, 1'b0, 7'b0110100};
    tbl[6]  = '{1'b0, 1'b0, 7'b0110100};
    tbl[7]  = '{1'b0, 1'b0, 7'b0010100};
    tbl[8]  = '{1'b0, 1'b0, 7'b0010100};
    tbl[9]  = '{1'b0, 1'b0, 7'b0110101};
    tbl[10] = '{1'b0, 1'b0, 7'b0110101};
    tbl[11] = '{1'b0, 1'b0, 7'b0010101};
    tbl[12] = '{1'b0, 1'b0, 7'b0010101};
    tbl[13] = '{1'b0, 1'b0, 7'b0110110};
    tbl[14] = '{1'b0, 1'b0, 7'b0110110};
    tbl[15] = '{1'b0, 1'b0, 7'b0010110};
    tbl[16] = '{1'b0, 1'b0, 7'b0010110};
    tbl[17] = '{1'b0, 1'b0, 7'b0110111};
    tbl[18] = '{1'b0, 1'b0, 7'b0110111};
    tbl[19] = '{1'b0, 1'b0, 7'b0010111};
    tbl[20] = '{1'b0, 1'b0, 7'b0010111};
    tbl[21] = '{1'b0, 1'b0, 7'b0001111};
    tbl[22] = '{1'b0, 1'b0, 7'b0000000};
    tbl[23] = '{1'b0, 1'b0, 7'b0000000};

    repeat (3) step();
    check("reset_outputs", obs, 0);
    check("reset_outputs_edge", obs_e, 0);
    rst_n = 1'b1;
    step();

    // Basic frame from the vector table
    for (int i = 0; i < 24; i++) begin
      req = tbl[i].req;
      abort = tbl[i].abort;
      step();
      check($sformatf("basic_c%0d", i + 1), obs, tbl[i].exp);
    end

    // Request held high across several frames
    req = 1'b1; first_stb = -1; stray = 0; busy_low = 0; prev_sp = 1'b0;
    rises.delete();
    for (int c = 1; c <= 46; c++) begin
      step();
      if (sp && !prev_sp) rises.push_back(c);
      prev_sp = sp;
      if (stb && first_stb < 0) first_stb = c;
      if (trig && !win) stray++;
      if (!busy) busy_low++;
    end
    req = 1'b0;
    check("held_first_sp", (rises.size() > 0) ? rises[0] : -1, 1);
    check("held_second_sp", (rises.size() > 1) ? rises[1] : -1, AUTO ? 23 : 24);
    check("held_first_strobe", first_stb, 22);
    check("held_stray_trig", stray, 0);
    check("held_busy_low_cycles", busy_low, AUTO ? 0 : 2);
    wait_idle("held_drain_idle");

    // Abort at cycle 11
    trig_rises = 0; n_stb = 0; prev_trig = 1'b0;
    for (int c = 0; c < 16; c++) begin
      req = (c == 0);
      abort = (c == 11);
      step();
      if (trig && !prev_trig) trig_rises++;
      prev_trig = trig;
      if (stb) n_stb++;
      if (c + 1 == 12) check("abort_c12_trig_win_stb", {trig, win, stb}, 3'b001);
      if (c + 1 == 13) check("abort_c13_busy_stb", {busy, stb}, 2'b00);
    end
    abort = 1'b0;
    check("abort_trig_pulses", trig_rises, 2);
    check("abort_strobes", n_stb, 1);

    // Asynchronous reset mid-frame (cycle 8)
    for (int c = 0; c < 8; c++) begin
      req = (c == 0);
      step();
    end
    check("prereset_active", {win, busy}, 2'b11);
    #3 rst_n = 1'b0;
    #1 check("reset_async_drop", obs, 0);
    n_stb = 0;
    repeat (2) begin
      step();
      if (stb) n_stb++;
    end
    check("reset_no_strobe", n_stb, 0);
    check("reset_hold_outputs", obs, 0);
    rst_n = 1'b1;
    step();
    trig_rises = 0; first_stb = -1; prev_trig = 1'b0;
    for (int c = 0; c < 24; c++) begin
      req = (c == 0);
      step();
      if (trig && !prev_trig) trig_rises++;
      prev_trig = trig;
      if (stb && first_stb < 0) first_stb = c + 1;
    end
    check("post_reset_trig_pulses", trig_rises, 4);
    check("post_reset_strobe_cycle", first_stb, 22);

    // Edge configuration: no gap, single pixel
    first_trig = -1; first_stb = -1; trig_rises = 0; prev_trig = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_e = (c == 0);
      step();
      if (trig_e && !prev_trig) begin
        trig_rises++;
        if (first_trig < 0) first_trig = c + 1;
      end
      prev_trig = trig_e;
      if (stb_e && first_stb < 0) first_stb = c + 1;
    end
    check("edge_trig_rise", first_trig, 3);
    check("edge_strobe", first_stb, 7);
    check("edge_trig_pulses", trig_rises, 1);
    check("edge_idle_after", busy_e, 0);

    // Randomized traffic against the timeline model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_active = 0; m_k = 0; m_endk = 0; m_pix_last = 0; hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) hold = 1'($urandom_range(0, 1));
      r = hold ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 49) == 0);
      req = r;
      abort = a;
      model_step(r, a);
      model_out(e);
      step();
      check($sformatf("rand_c%0d", c), obs, e);
    end
    req = 1'b0; abort = 1'b0;
    wait_idle("rand_drain_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
